// File: rtl/tff_pkg.sv
// Shared definitions for toggle flip-flop cells and the counter blocks
// that build on them.
package tff_pkg;

  localparam int TFF_DEFAULT_WIDTH = 1;

  // State vector at the default width, for counters instantiating this cell.
  typedef logic [TFF_DEFAULT_WIDTH-1:0] tff_state_t;

endpackage : tff_pkg

// File: rtl/tff_from_dff_if.sv
// Toggle-enable / state bundle between a T flip-flop vector and its user.
interface tff_from_dff_if
  import tff_pkg::*;
#(
  parameter int WIDTH = TFF_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;

  modport master (output t, input q, input q_n);
  modport slave  (input t, output q, output q_n);

endinterface : tff_from_dff_if

// File: rtl/dff_sync_rst.sv
// WIDTH-wide D register with synchronous active-high reset to RESET_VALUE.
module dff_sync_rst #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule : dff_sync_rst

// File: rtl/tff_from_dff.sv
// Vector of independent T flip-flops: a D register fed back through q ^ t.
module tff_from_dff
  import tff_pkg::*;
#(
  parameter int               WIDTH       = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  tff_from_dff_if.slave   bus
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  assign d = q ^ bus.t;

  dff_sync_rst #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  assign bus.q   = q;
  assign bus.q_n = ~q;

endmodule : tff_from_dff

// File: tb/tb_tff_from_dff.sv
// Randomised and directed checks of tff_from_dff at WIDTH=1 and WIDTH=4,
// against a toggle-counting reference model.
module tb_tff_from_dff;

  localparam logic [3:0] RV4R = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: toggles seen per bit since the last reset.
  int cnt1;
  int cnt4  [4];
  int cnt4r [4];

  always #5 clk = ~clk;

  tff_from_dff_if #(.WIDTH(1)) bus1  ();
  tff_from_dff_if #(.WIDTH(4)) bus4  ();
  tff_from_dff_if #(.WIDTH(4)) bus4r ();

  tff_from_dff #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  tff_from_dff #(.WIDTH(4), .RESET_VALUE(4'b0000)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  tff_from_dff #(.WIDTH(4), .RESET_VALUE(RV4R)) u_dut4r (.clk(clk), .rst(rst), .bus(bus4r));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, update the model and compare.
  task automatic apply(input logic r, input logic t1, input logic [3:0] t4, input logic [3:0] t4r);
    logic       e1, en1;
    logic [3:0] e4, en4, e4r, en4r;
    rst      = r;
    bus1.t   = t1;
    bus4.t   = t4;
    bus4r.t  = t4r;
    @(posedge clk);
    #1;
    if (r) begin
      cnt1 = 0;
      for (int i = 0; i < 4; i++) begin
        cnt4[i]  = 0;
        cnt4r[i] = 0;
      end
    end else begin
      cnt1 += int'(t1);
      for (int i = 0; i < 4; i++) begin
        cnt4[i]  += int'(t4[i]);
        cnt4r[i] += int'(t4r[i]);
      end
    end
    e1 = (cnt1 % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      e4[i]  = (cnt4[i] % 2) == 1;
      e4r[i] = RV4R[i] ^ ((cnt4r[i] % 2) == 1);
    end
    en1  = ~e1;
    en4  = ~e4;
    en4r = ~e4r;
    check("q_w1",    32'(bus1.q),    32'(e1));
    check("qn_w1",   32'(bus1.q_n),  32'(en1));
    check("q_w4",    32'(bus4.q),    32'(e4));
    check("qn_w4",   32'(bus4.q_n),  32'(en4));
    check("q_w4r",   32'(bus4r.q),   32'(e4r));
    check("qn_w4r",  32'(bus4r.q_n), 32'(en4r));
  endtask

  initial begin
    logic       tog_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] vt4     [3] = '{4'b0101, 4'b0101, 4'b1111};
    logic [3:0] vq4     [3] = '{4'b0101, 4'b0000, 4'b1111};
    logic [3:0] vt4r    [3] = '{4'b0011, 4'b0000, 4'b0000};
    logic [3:0] vq4r    [3] = '{4'b1001, 4'b1001, 4'b1001};
    logic       r;
    logic       t1;
    logic [3:0] t4, t4r;

    bus1.t  = '0;
    bus4.t  = '0;
    bus4r.t = '0;
    cnt1    = 0;
    for (int i = 0; i < 4; i++) begin
      cnt4[i]  = 0;
      cnt4r[i] = 0;
    end
    @(negedge clk);

    // Reset with t=0.
    apply(1'b1, 1'b0, 4'b0000, 4'b0000);
    check("rst_q1",  32'(bus1.q),    32'd0);
    check("rst_qn1", 32'(bus1.q_n),  32'd1);
    check("rst_q4r", 32'(bus4r.q),   32'(4'b1010));

    // Hold for three edges.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 4'b0000, 4'b0000);
      check("hold_q1", 32'(bus1.q), 32'd0);
    end

    // Sustained toggle: divide-by-2.
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b1, 4'b0000, 4'b0000);
      check("tog_seq", 32'(bus1.q), 32'(tog_seq[k]));
    end

    // Reset overrides a pending toggle while q=1, then no dead cycle.
    apply(1'b1, 1'b1, 4'b1111, 4'b1111);
    check("rst_ovr_q1", 32'(bus1.q), 32'd0);
    check("rst_ovr_q4", 32'(bus4.q), 32'd0);

    // Vector mode right after reset release.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, vt4[k], vt4r[k]);
      if (k == 0) check("no_dead_q1", 32'(bus1.q), 32'd1);
      check("vec_q4",  32'(bus4.q),  32'(vq4[k]));
      check("vec_q4r", 32'(bus4r.q), 32'(vq4r[k]));
    end

    // Random traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      r   = ($urandom_range(0, 15) == 0);
      t1  = 1'($urandom);
      t4  = 4'($urandom);
      t4r = 4'($urandom);
      apply(r, t1, t4, t4r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tff_from_dff
